// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - reassembles 2x2 matmul results into frames and streams them bytewise
module systolic_result_collector #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_uo,
    input  logic [7:0]       in_uio,
    input  logic [7:0]       in_oe,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             trunc_err,
    input  logic             clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic STATE_WAIT_B1 = 1'b0;
    localparam logic STATE_WAIT_B2 = 1'b1;

    logic          state_q;
    logic [7:0]    c00_q;
    logic [7:0]    c01_q;

    // Frame slots hold {C00, C01, C10, C11}, C00 in the top byte.
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    idx_q;

    logic          oe_hit;
    logic          commit;
    logic          trunc_set;
    logic [31:0]   new_frame;
    logic          xfer;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;
    logic [AW-1:0] rd_ptr_nx;
    logic [CW-1:0] count_rem;
    logic [CW-1:0] count_nx;
    logic [1:0]    idx_nx;
    logic [31:0]   head_nx;
    logic          valid_nx;
    logic [7:0]    byte_nx;
    logic [7:0]    data_nx;
    logic          last_nx;

    // Next-state computation for capture, FIFO occupancy and the registered output byte.
    // The output register is loaded from the head frame the FIFO will have after this edge;
    // when the FIFO drains to empty the incoming frame is bypassed straight to the output.
    always_comb begin
        oe_hit    = (in_oe == 8'hFF);
        commit    = (state_q == STATE_WAIT_B2) && oe_hit;
        trunc_set = (state_q == STATE_WAIT_B2) && !oe_hit;
        new_frame = {c00_q, c01_q,
                     in_uio[7:4], in_uo[7:4],
                     in_uio[3:0], in_uo[3:0]};
        xfer      = m_valid && m_ready;
        pop       = xfer && (idx_q == 2'd3);
        full      = (count_q == DEPTH_C);
        push      = commit && (!full || pop);
        drop      = commit && !push;
        rd_ptr_nx = rd_ptr_q + AW'(pop);
        count_rem = count_q - CW'(pop);
        count_nx  = count_rem + CW'(push);
        idx_nx    = xfer ? idx_q + 2'd1 : idx_q;
        head_nx   = (count_rem == '0) ? new_frame : mem[rd_ptr_nx];
        valid_nx  = (count_nx != '0);
        case (idx_nx)
            2'd0:    byte_nx = head_nx[31:24];
            2'd1:    byte_nx = head_nx[23:16];
            2'd2:    byte_nx = head_nx[15:8];
            default: byte_nx = head_nx[7:0];
        endcase
        data_nx   = valid_nx ? byte_nx : 8'h00;
        last_nx   = valid_nx && (idx_nx == 2'd3);
    end

    // Beat capture FSM: beat1 latches C00/C01, beat2 completes the frame or a gap truncates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_WAIT_B1;
            c00_q   <= 8'h00;
            c01_q   <= 8'h00;
        end else begin
            case (state_q)
                STATE_WAIT_B1: begin
                    if (oe_hit) begin
                        c00_q   <= {in_uio[7:4], in_uo[7:4]};
                        c01_q   <= {in_uio[3:0], in_uo[3:0]};
                        state_q <= STATE_WAIT_B2;
                    end
                end
                default: begin
                    state_q <= STATE_WAIT_B1;
                end
            endcase
        end
    end

    // Frame storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= new_frame;
        end
    end

    // FIFO pointers, occupancy, byte index and the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= 2'd0;
            m_valid  <= 1'b0;
            m_data   <= 8'h00;
            m_last   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_nx;
            count_q  <= count_nx;
            idx_q    <= idx_nx;
            m_valid  <= valid_nx;
            m_data   <= data_nx;
            m_last   <= last_nx;
        end
    end

    // Saturating frame/drop counters and sticky truncation flag; a clear beats a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            drop_count  <= '0;
            trunc_err   <= 1'b0;
        end else if (clr_err) begin
            frame_count <= '0;
            drop_count  <= '0;
            trunc_err   <= 1'b0;
        end else begin
            if (push && (frame_count != '1)) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (trunc_set) begin
                trunc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - scoreboard bench for systolic_result_collector
module tb_systolic_result_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_uo = 8'h00;
    logic [7:0] in_uio = 8'h00;
    logic [7:0] in_oe = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_last;
    logic [7:0] frame_count;
    logic [7:0] drop_count;
    logic       trunc_err;
    logic       clr_err = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    systolic_result_collector #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_uo       (in_uo),
        .in_uio      (in_uio),
        .in_oe       (in_oe),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .trunc_err   (trunc_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: present m_ready, score any transfer happening at the coming edge, advance.
    task automatic tick(input logic ready);
        logic [8:0] e;
        m_ready = ready;
        if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         m_valid, m_data, m_last, prev_data, prev_last);
            end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: data=%h last=%b, required no transfer", m_data, m_last);
            end else begin
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    errors++;
                    $display("FAIL stream_byte: data=%h last=%b, required data=%h last=%b",
                             m_data, m_last, e[7:0], e[8]);
                end
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] uio, input logic [7:0] uo, input logic [7:0] oe,
                             input logic ready);
        in_uio = uio;
        in_uo  = uo;
        in_oe  = oe;
        tick(ready);
    endtask

    task automatic idle(input logic ready);
        in_oe = 8'h00;
        tick(ready);
    endtask

    task automatic push_exp(input logic [7:0] c00, input logic [7:0] c01,
                            input logic [7:0] c10, input logic [7:0] c11);
        exp_q.push_back({1'b0, c00});
        exp_q.push_back({1'b0, c01});
        exp_q.push_back({1'b0, c10});
        exp_q.push_back({1'b1, c11});
    endtask

    task automatic send_frame(input logic [7:0] c00, input logic [7:0] c01,
                              input logic [7:0] c10, input logic [7:0] c11, input logic ready);
        send_beat({c00[7:4], c01[7:4]}, {c00[3:0], c01[3:0]}, 8'hFF, ready);
        send_beat({c10[7:4], c11[7:4]}, {c10[3:0], c11[3:0]}, 8'hFF, ready);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid === 1'b1) && n < max_cycles) begin
            idle(1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: pending=%0d valid=%b after %0d cycles, required pending=0 valid=0",
                     exp_q.size(), m_valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b, required 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: %h, required 00", m_data); end
        checks++;
        if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: %b, required 0", m_last); end
        checks++;
        if (frame_count !== 8'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: frame=%0d drop=%0d, required 0/0", frame_count, drop_count);
        end
        checks++;
        if (trunc_err !== 1'b0) begin errors++; $display("FAIL reset_trunc: %b, required 0", trunc_err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        push_exp(8'h13, 8'h16, 8'h2B, 8'h32);
        send_beat(8'h11, 8'h36, 8'hFF, 1'b1);
        send_beat(8'h23, 8'hB2, 8'hFF, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h13 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL first_byte_latency: valid=%b data=%h last=%b, required 1/13/0",
                     m_valid, m_data, m_last);
        end
        drain(20);
        checks++;
        if (frame_count !== 8'd1) begin errors++; $display("FAIL single_frame_count: %0d, required 1", frame_count); end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat = 7'b1110100;
        push_exp(8'h13, 8'h16, 8'h2B, 8'h32);
        send_frame(8'h13, 8'h16, 8'h2B, 8'h32, 1'b0);
        for (int i = 0; i < 7; i++) begin
            idle(pat[i]);
        end
        checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done: pending=%0d valid=%b, required 0/0", exp_q.size(), m_valid);
        end
        drain(20);
        checks++;
        if (frame_count !== 8'd2) begin errors++; $display("FAIL backpressure_count: %0d, required 2", frame_count); end
    endtask

    task automatic test_truncation();
        send_beat(8'h11, 8'h36, 8'hFF, 1'b1);
        idle(1'b1);
        checks++;
        if (trunc_err !== 1'b1 || m_valid !== 1'b0 || frame_count !== 8'd2) begin
            errors++;
            $display("FAIL trunc_set: trunc=%b valid=%b frames=%0d, required 1/0/2", trunc_err, m_valid, frame_count);
        end
        push_exp(8'hA5, 8'h3C, 8'h7E, 8'h81);
        send_frame(8'hA5, 8'h3C, 8'h7E, 8'h81, 1'b1);
        drain(20);
        checks++;
        if (trunc_err !== 1'b1 || frame_count !== 8'd3) begin
            errors++;
            $display("FAIL trunc_recover: trunc=%b frames=%0d, required 1/3", trunc_err, frame_count);
        end
        clr_err = 1'b1;
        idle(1'b1);
        clr_err = 1'b0;
        checks++;
        if (trunc_err !== 1'b0 || frame_count !== 8'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_err: trunc=%b frames=%0d drops=%0d, required 0/0/0", trunc_err, frame_count, drop_count);
        end
        // clear coinciding with a truncation
        send_beat(8'h44, 8'h55, 8'hFF, 1'b1);
        clr_err = 1'b1;
        idle(1'b1);
        clr_err = 1'b0;
        checks++;
        if (trunc_err !== 1'b0) begin errors++; $display("FAIL clr_wins_trunc: %b, required 0", trunc_err); end
        // clear coinciding with a commit: frame still streams, count stays 0
        push_exp(8'h12, 8'h34, 8'h56, 8'h78);
        send_beat(8'h13, 8'h24, 8'hFF, 1'b1);
        clr_err = 1'b1;
        send_beat(8'h57, 8'h68, 8'hFF, 1'b1);
        clr_err = 1'b0;
        checks++;
        if (frame_count !== 8'd0) begin errors++; $display("FAIL clr_wins_count: %0d, required 0", frame_count); end
        drain(20);
    endtask

    task automatic test_overflow();
        push_exp(8'h01, 8'h02, 8'h03, 8'h04);
        push_exp(8'hF0, 8'hE1, 8'hD2, 8'hC3);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        send_frame(8'hF0, 8'hE1, 8'hD2, 8'hC3, 1'b0);
        send_frame(8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
        checks++;
        if (frame_count !== 8'd2 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL overflow_counts: frames=%0d drops=%0d, required 2/1", frame_count, drop_count);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            errors++;
            $display("FAIL overflow_head: valid=%b data=%h, required 1/01", m_valid, m_data);
        end
        drain(40);
    endtask

    task automatic test_full_pop();
        clr_err = 1'b1;
        idle(1'b0);
        clr_err = 1'b0;
        push_exp(8'h9A, 8'hBC, 8'hDE, 8'hF1);
        push_exp(8'h21, 8'h43, 8'h65, 8'h87);
        push_exp(8'hC0, 8'hFF, 8'h0E, 8'h5D);
        send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF1, 1'b0);
        send_frame(8'h21, 8'h43, 8'h65, 8'h87, 1'b0);
        idle(1'b1);
        idle(1'b1);
        // beat2 of the third frame lands on the edge that pops the first frame's C11
        send_frame(8'hC0, 8'hFF, 8'h0E, 8'h5D, 1'b1);
        checks++;
        if (frame_count !== 8'd3 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL full_pop_counts: frames=%0d drops=%0d, required 3/0", frame_count, drop_count);
        end
        drain(40);
    endtask

    task automatic test_partial_oe();
        logic [7:0] fc;
        logic [7:0] dc;
        fc = frame_count;
        dc = drop_count;
        send_beat(8'h11, 8'h36, 8'hF0, 1'b1);
        send_beat(8'h23, 8'hB2, 8'h0F, 1'b1);
        send_beat(8'h11, 8'h36, 8'hFE, 1'b1);
        idle(1'b1);
        checks++;
        if (frame_count !== fc || drop_count !== dc || trunc_err !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_oe: frames=%0d drops=%0d trunc=%b valid=%b, required %0d/%0d/0/0",
                     frame_count, drop_count, trunc_err, m_valid, fc, dc);
        end
        push_exp(8'h6C, 8'h93, 8'h00, 8'hFF);
        send_frame(8'h6C, 8'h93, 8'h00, 8'hFF, 1'b1);
        drain(20);
        checks++;
        if (frame_count !== fc + 8'd1) begin
            errors++;
            $display("FAIL partial_oe_followup: frames=%0d, required %0d", frame_count, fc + 8'd1);
        end
    endtask

    task automatic test_async_reset();
        push_exp(8'h13, 8'h16, 8'h2B, 8'h32);
        send_frame(8'h13, 8'h16, 8'h2B, 8'h32, 1'b1);
        idle(1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_out: valid=%b data=%h last=%b, required 0/00/0", m_valid, m_data, m_last);
        end
        checks++;
        if (frame_count !== 8'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_counts: frames=%0d drops=%0d, required 0/0", frame_count, drop_count);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_exp(8'h3E, 8'h4F, 8'h50, 8'h61);
        send_frame(8'h3E, 8'h4F, 8'h50, 8'h61, 1'b1);
        drain(20);
        checks++;
        if (frame_count !== 8'd1) begin errors++; $display("FAIL post_reset_count: %0d, required 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_truncation();
        test_overflow();
        test_full_pop();
        test_partial_oe();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
Downstream stage of the 2x2 systolic matmul core. It samples the core's two-beat, nibble-split result bus and reassembles the four 8-bit products C00, C01, C10, C11. Completed frames are buffered in a small frame FIFO. Bytes are then streamed out over a valid/ready interface, in order C00, C01, C10, C11, with a last marker on C11.

Parameters:
FIFO_DEPTH, 2, frame slots in buffer (power of 2, >=2)
CNT_W, 8, width of frame/drop counters (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_uo  in  8  core uo_out: beat1 {C00[3:0],C01[3:0]}, beat2 {C10[3:0],C11[3:0]}
in_uio  in  8  core uio_out: beat1 {C00[7:4],C01[7:4]}, beat2 {C10[7:4],C11[7:4]}
in_oe  in  8  core uio_oe; beat present only when ==8'hFF
m_data  out  8  output byte
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts
m_last  out  1  high with C11 byte
frame_count  out  CNT_W  frames accepted into FIFO
drop_count  out  CNT_W  frames dropped (FIFO full)
trunc_err  out  1  sticky: beat1 seen without beat2
clr_err  in  1  synchronous clear of trunc_err, drop_count, frame_count

Behaviour:
- Reset (async, rst=1): FSM->WAIT_B1, FIFO empty, m_valid=0, m_data=0, m_last=0, counters=0, trunc_err=0. Reset mid-frame or mid-stream discards everything.
- Beat qualifier: oe_hit = (in_oe==8'hFF). Any other value, including partial, counts as no beat.
- Capture FSM:
  - WAIT_B1: on oe_hit latch c00={in_uio[7:4],in_uo[7:4]} and c01={in_uio[3:0],in_uo[3:0]} -> WAIT_B2.
  - WAIT_B2: on oe_hit form c10 and c11 with the same mapping, then commit the frame -> WAIT_B1.
  - WAIT_B2 with !oe_hit: set trunc_err, discard the partial frame -> WAIT_B1.
  - A third consecutive oe_hit is beat1 of a new frame.
- Commit: the frame is written to the FIFO at the edge that samples beat2.
  - If the FIFO is full at that edge (after any same-edge pop of a final C11 byte), the frame is dropped and drop_count increments.
  - Otherwise frame_count increments.
  - Both counters saturate at all-ones.
- Output: m_data, m_valid and m_last are registered.
  - First byte of a frame written into an empty FIFO appears with m_valid=1 one cycle after the commit edge.
  - A byte transfers when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_last are held stable.
  - Byte index 0..3 advances per transfer. The transfer at index 3 (m_last=1) pops the frame; if another frame is queued, its C00 is presented next cycle with no bubble.
  - m_valid must not drop without a transfer.
- Simultaneous commit and last-byte pop when full: the slot is freed and the write is accepted.
- clr_err: counters and trunc_err cleared. If the same cycle sets trunc_err or a counter increments, the clear wins.
- No combinational path from m_ready to m_valid or m_data.

Test Plan:
1. Single frame. After reset, drive 0x11/0x36 then 0x23/0xB2 on in_uio/in_uo with in_oe=0xFF for 2 cycles, m_ready=1 -> m_data 0x13, 0x16, 0x2B, 0x32 (C=[[19,22],[43,50]]). m_last only on 0x32. frame_count=1.
2. Backpressure. Same frame, m_ready toggled 0,0,1,0,1,1,1 -> same four bytes in order. Data stable during stalls. No duplicated or lost byte.
3. Truncation. in_oe=0xFF one cycle then 0x00 -> trunc_err=1, no m_valid. A following good frame streams correctly. clr_err -> trunc_err=0.
4. Overflow. m_ready=0, send 3 back-to-back frames (6 oe_hit cycles) with FIFO_DEPTH=2 -> frame_count=2, drop_count=1. Releasing m_ready yields the first two frames only, 8 bytes, two m_last pulses.
5. Partial OE. in_oe=0xF0 with valid-looking data -> ignored, FSM stays WAIT_B1, no counters change.
6. Async reset mid-stream. Assert rst between bytes 1 and 2 -> m_valid=0 and counters=0 immediately. The next frame streams from C00.
